mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (request driven by the pc register's address and chip enable) and the MEM stage (load/store).
- Sequences each access as a multi-cycle req/ack transaction.
- Raises per-requester stall requests to ctrl while an access is pending.
- Handles branch flushes by discarding an in-flight fetch.
- Sits between the pipeline (pc_reg/if_id, mem stage) and the RAM interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles ram_req_o may stay unacked before bus_err_o is set.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- if_req_i  input  1  fetch request; level, held until served.
- if_addr_i  input  ADDR_W  fetch address.
- if_data_o  output  DATA_W  fetched instruction; valid when if_valid_o.
- if_valid_o  output  1  fetch completes this cycle.
- mem_req_i  input  1  data request; level, held until served.
- mem_we_i  input  1  1 = store.
- mem_sel_i  input  4  byte enables.
- mem_addr_i  input  ADDR_W  data address.
- mem_data_i  input  DATA_W  store data.
- mem_data_o  output  DATA_W  load data; valid when mem_valid_o.
- mem_valid_o  output  1  data access completes this cycle.
- flush_i  input  1  taken branch; the outstanding fetch result is void.
- ram_req_o  output  1  RAM request.
- ram_we_o  output  1  RAM write enable.
- ram_sel_o  output  4  RAM byte enables.
- ram_addr_o  output  ADDR_W  RAM address.
- ram_data_o  output  DATA_W  RAM write data.
- ram_data_i  input  DATA_W  RAM read data; valid with ram_ack_i.
- ram_ack_i  input  1  single-cycle completion pulse.
- stallreq_if_o  output  1  to ctrl: fetch not yet done.
- stallreq_mem_o  output  1  to ctrl: data access not yet done.
- bus_err_o  output  1  sticky timeout flag.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; ram_req_o, ram_we_o=0; ram_sel_o, ram_addr_o, ram_data_o=0.
  - Timeout counter=0; bus_err_o=0.
  - Combinational outputs follow from IDLE: valids 0; stalls equal the raw requests.
  - Reset mid-transaction abandons it; any later ram_ack_i seen in IDLE is ignored.
- States: IDLE, IF_BUSY, MEM_BUSY, IF_DISCARD. The ram_* outputs are registered and held constant for the whole transaction.
- IDLE:
  - mem_req_i=1: latch mem_* fields onto ram_*, ram_req_o<=1, go MEM_BUSY. MEM has fixed priority because it is the older instruction.
  - Else if_req_i=1: latch if_addr_i, ram_we_o<=0, ram_sel_o<=4'hF, ram_req_o<=1, go IF_BUSY. If flush_i=1 in this cycle, do not issue the fetch; stay IDLE.
- MEM_BUSY:
  - On ram_ack_i: mem_valid_o=1 combinationally that cycle; mem_data_o=ram_data_i for loads, 0 for stores.
  - Next state IDLE; ram_req_o<=0.
- IF_BUSY:
  - ram_ack_i & ~flush_i: if_valid_o=1, if_data_o=ram_data_i; go IDLE.
  - ram_ack_i & flush_i: if_valid_o=0; go IDLE.
  - flush_i without ack: go IF_DISCARD. The request cannot be aborted, so ram_req_o stays 1.
- IF_DISCARD: wait for ram_ack_i, suppress if_valid_o, then go IDLE.
- Data outputs are 0 whenever the corresponding valid is 0.
- Stall requests (combinational):
  - stallreq_if_o = if_req_i & ~if_valid_o.
  - stallreq_mem_o = mem_req_i & ~mem_valid_o.
  - Low in the ack cycle, so the pipeline advances at that edge.
- Minimum latency: request at cycle t → ram_req_o high at t+1 → earliest ack/valid at t+1 (RAM zero-wait) → arbiter back in IDLE at t+2.
- A request still held high in IDLE is treated as new; requesters must present the next address after advancing.
- Timeout:
  - Counter increments each cycle ram_req_o=1 & ~ram_ack_i; clears on ack.
  - Reaching TIMEOUT sets bus_err_o sticky until rst. The transaction keeps waiting.

Test Plan:
- Fetch only, RAM acks 2 cycles after ram_req_o, if_addr_i=0x100, data 0x24020005 → ram_addr_o=0x100, sel=F, we=0; if_valid_o=1 with if_data_o=0x24020005 in the ack cycle; stallreq_if_o=1 until then.
- if_req_i and mem_req_i rise together (load 0x200, data 0xDEADBEEF) → MEM served first; mem_data_o=0xDEADBEEF; fetch issues the cycle after return to IDLE; stallreq_if_o stays high throughout.
- Store mem_we_i=1, sel=4'b0011, addr 0x300, data 0x1234 → ram_* carry the exact values, held until ack; mem_valid_o=1, mem_data_o=0.
- flush_i pulsed 1 cycle into IF_BUSY, ack 3 cycles later → state IF_DISCARD; if_valid_o never asserts; the next fetch (new target 0x400) issues after return to IDLE.
- Set rst in MEM_BUSY, then send a late ram_ack_i → ram_req_o=0 after the edge; no valid pulse; bus_err_o=0.
- Never ack with TIMEOUT=4 → bus_err_o rises after the 4th unacked cycle and stays 1 until rst.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and the MEM stage.
// Each access is one registered req/ack transaction. A fetch voided by a branch flush is drained, not aborted.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_valid_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_valid_o,
  input  logic              flush_i,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_ack_i,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o,
  output logic              bus_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, IF_DISCARD} state_t;

  state_t            r_state;
  logic              r_ram_req;
  logic              r_ram_we;
  logic [3:0]        r_ram_sel;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bus_err;

  logic              w_if_done;
  logic              w_mem_done;

  // Transaction sequencer and timeout watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ram_req  <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_sel  <= 4'h0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      if (ram_ack_i) begin
        r_cnt <= '0;
      end else if (r_ram_req) begin
        if (r_cnt != CNT_W'(TIMEOUT)) r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt >= CNT_W'(TIMEOUT - 1)) r_bus_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          // MEM holds the older instruction, so it always wins
          if (mem_req_i) begin
            r_ram_req  <= 1'b1;
            r_ram_we   <= mem_we_i;
            r_ram_sel  <= mem_sel_i;
            r_ram_addr <= mem_addr_i;
            r_ram_data <= mem_data_i;
            r_state    <= MEM_BUSY;
          end else if (if_req_i && !flush_i) begin
            r_ram_req  <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_sel  <= 4'hF;
            r_ram_addr <= if_addr_i;
            r_ram_data <= '0;
            r_state    <= IF_BUSY;
          end
        end
        MEM_BUSY: begin
          if (ram_ack_i) begin
            r_ram_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        IF_BUSY: begin
          if (ram_ack_i) begin
            r_ram_req <= 1'b0;
            r_state   <= IDLE;
          end else if (flush_i) begin
            r_state <= IF_DISCARD;
          end
        end
        IF_DISCARD: begin
          if (ram_ack_i) begin
            r_ram_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Completion is only recognised in the matching busy state, so stray acks are dropped
  assign w_if_done  = (r_state == IF_BUSY) && ram_ack_i && !flush_i;
  assign w_mem_done = (r_state == MEM_BUSY) && ram_ack_i;

  assign if_valid_o     = w_if_done;
  assign if_data_o      = w_if_done ? ram_data_i : '0;
  assign mem_valid_o    = w_mem_done;
  assign mem_data_o     = (w_mem_done && !r_ram_we) ? ram_data_i : '0;
  assign stallreq_if_o  = if_req_i & ~w_if_done;
  assign stallreq_mem_o = mem_req_i & ~w_mem_done;

  assign ram_req_o  = r_ram_req;
  assign ram_we_o   = r_ram_we;
  assign ram_sel_o  = r_ram_sel;
  assign ram_addr_o = r_ram_addr;
  assign ram_data_o = r_ram_data;
  assign bus_err_o  = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change just after negedge, outputs checked 1ns later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_valid_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_valid_o;
  logic        flush_i;
  logic        ram_req_o;
  logic        ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;
  logic        ram_ack_i;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_err_o;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_valid_o(if_valid_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_valid_o(mem_valid_o),
    .flush_i(flush_i),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    mem_sel_i = 4'h0; mem_addr_i = '0; mem_data_i = '0; flush_i = 1'b0;
    ram_data_i = '0; ram_ack_i = 1'b0;

    // Reset state; stalls follow raw requests
    tick(); tick();
    if_req_i = 1'b1; settle();
    chk("rst_req", 32'(ram_req_o), 32'd0);
    chk("rst_we", 32'(ram_we_o), 32'd0);
    chk("rst_sel", 32'(ram_sel_o), 32'h0);
    chk("rst_addr", ram_addr_o, 32'h0);
    chk("rst_data", ram_data_o, 32'h0);
    chk("rst_err", 32'(bus_err_o), 32'd0);
    chk("rst_ifv", 32'(if_valid_o), 32'd0);
    chk("rst_memv", 32'(mem_valid_o), 32'd0);
    chk("rst_stall_if", 32'(stallreq_if_o), 32'd1);
    chk("rst_stall_mem", 32'(stallreq_mem_o), 32'd0);

    // Fetch 0x100 with ack two cycles after ram_req_o rises
    tick(); rst = 1'b0; if_addr_i = 32'h100; settle();
    chk("f1_idle_req", 32'(ram_req_o), 32'd0);
    tick(); settle();
    chk("f1_req", 32'(ram_req_o), 32'd1);
    chk("f1_addr", ram_addr_o, 32'h100);
    chk("f1_sel", 32'(ram_sel_o), 32'hF);
    chk("f1_we", 32'(ram_we_o), 32'd0);
    chk("f1_stall_w0", 32'(stallreq_if_o), 32'd1);
    tick(); settle();
    chk("f1_stall_w1", 32'(stallreq_if_o), 32'd1);
    chk("f1_nov", 32'(if_valid_o), 32'd0);
    tick(); ram_ack_i = 1'b1; ram_data_i = 32'h24020005; settle();
    chk("f1_valid", 32'(if_valid_o), 32'd1);
    chk("f1_data", if_data_o, 32'h24020005);
    chk("f1_stall_ack", 32'(stallreq_if_o), 32'd0);
    tick(); ram_ack_i = 1'b0; if_req_i = 1'b0; settle();
    chk("f1_done_req", 32'(ram_req_o), 32'd0);
    chk("f1_done_data", if_data_o, 32'h0);

    // Simultaneous load and fetch: load wins
    tick(); if_req_i = 1'b1; if_addr_i = 32'h104;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h200; settle();
    chk("p_stall_if0", 32'(stallreq_if_o), 32'd1);
    tick(); settle();
    chk("p_addr", ram_addr_o, 32'h200);
    chk("p_we", 32'(ram_we_o), 32'd0);
    chk("p_stall_mem", 32'(stallreq_mem_o), 32'd1);
    tick(); ram_ack_i = 1'b1; ram_data_i = 32'hDEADBEEF; settle();
    chk("p_memv", 32'(mem_valid_o), 32'd1);
    chk("p_memd", mem_data_o, 32'hDEADBEEF);
    chk("p_ifv", 32'(if_valid_o), 32'd0);
    chk("p_stall_mem_ack", 32'(stallreq_mem_o), 32'd0);
    chk("p_stall_if1", 32'(stallreq_if_o), 32'd1);
    tick(); ram_ack_i = 1'b0; mem_req_i = 1'b0; settle();
    chk("p_idle_req", 32'(ram_req_o), 32'd0);
    chk("p_stall_if2", 32'(stallreq_if_o), 32'd1);
    tick(); ram_ack_i = 1'b1; ram_data_i = 32'h11112222; settle();
    chk("p_f_addr", ram_addr_o, 32'h104);
    chk("p_f_valid", 32'(if_valid_o), 32'd1);
    chk("p_f_data", if_data_o, 32'h11112222);
    tick(); ram_ack_i = 1'b0; if_req_i = 1'b0; settle();

    // Store: exact fields held until ack, no load data returned
    tick(); mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h300; mem_data_i = 32'h1234; settle();
    tick(); mem_sel_i = 4'hF; mem_addr_i = 32'h0; mem_data_i = 32'h0; settle();
    chk("s_we", 32'(ram_we_o), 32'd1);
    chk("s_sel", 32'(ram_sel_o), 32'h3);
    chk("s_addr", ram_addr_o, 32'h300);
    chk("s_data", ram_data_o, 32'h1234);
    tick(); ram_ack_i = 1'b1; ram_data_i = 32'hFFFFFFFF; settle();
    chk("s_hold_addr", ram_addr_o, 32'h300);
    chk("s_hold_data", ram_data_o, 32'h1234);
    chk("s_memv", 32'(mem_valid_o), 32'd1);
    chk("s_memd", mem_data_o, 32'h0);
    tick(); ram_ack_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0; settle();

    // Flush one cycle into a fetch; the voided fetch drains before the new target issues
    tick(); if_req_i = 1'b1; if_addr_i = 32'h180; settle();
    tick(); flush_i = 1'b1; settle();
    chk("fl_req", 32'(ram_req_o), 32'd1);
    chk("fl_nov0", 32'(if_valid_o), 32'd0);
    tick(); flush_i = 1'b0; if_addr_i = 32'h400; settle();
    chk("fl_disc_req", 32'(ram_req_o), 32'd1);
    chk("fl_disc_addr", ram_addr_o, 32'h180);
    chk("fl_nov1", 32'(if_valid_o), 32'd0);
    tick(); settle();
    tick(); ram_ack_i = 1'b1; ram_data_i = 32'h00000BAD; settle();
    chk("fl_ack_nov", 32'(if_valid_o), 32'd0);
    chk("fl_ack_data", if_data_o, 32'h0);
    chk("fl_stall", 32'(stallreq_if_o), 32'd1);
    chk("fl_err", 32'(bus_err_o), 32'd0);
    tick(); ram_ack_i = 1'b0; settle();
    chk("fl_idle_req", 32'(ram_req_o), 32'd0);
    tick(); ram_ack_i = 1'b1; ram_data_i = 32'h55; settle();
    chk("fl_new_addr", ram_addr_o, 32'h400);
    chk("fl_new_valid", 32'(if_valid_o), 32'd1);
    chk("fl_new_data", if_data_o, 32'h55);
    tick(); ram_ack_i = 1'b0; if_req_i = 1'b0; settle();

    // Flush while IDLE suppresses fetch issue for that cycle
    tick(); if_req_i = 1'b1; if_addr_i = 32'h500; flush_i = 1'b1; settle();
    tick(); flush_i = 1'b0; settle();
    chk("fi_no_issue", 32'(ram_req_o), 32'd0);
    tick(); ram_ack_i = 1'b1; ram_data_i = 32'h77; settle();
    chk("fi_addr", ram_addr_o, 32'h500);
    chk("fi_valid", 32'(if_valid_o), 32'd1);
    tick(); ram_ack_i = 1'b0; if_req_i = 1'b0; settle();

    // Reset during MEM_BUSY; late ack ignored
    tick(); mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h600; settle();
    tick(); settle();
    chk("r_busy_req", 32'(ram_req_o), 32'd1);
    rst = 1'b1; mem_req_i = 1'b0;
    tick(); rst = 1'b0; ram_ack_i = 1'b1; ram_data_i = 32'h99; settle();
    chk("r_req", 32'(ram_req_o), 32'd0);
    chk("r_addr", ram_addr_o, 32'h0);
    chk("r_memv", 32'(mem_valid_o), 32'd0);
    chk("r_memd", mem_data_o, 32'h0);
    chk("r_ifv", 32'(if_valid_o), 32'd0);
    chk("r_err", 32'(bus_err_o), 32'd0);
    tick(); ram_ack_i = 1'b0; settle();
    chk("r_req2", 32'(ram_req_o), 32'd0);

    // Timeout=4: error after the 4th unacked cycle, sticky until reset
    tick(); mem_req_i = 1'b1; mem_addr_i = 32'h700; settle();
    for (int i = 1; i <= 4; i++) begin
      tick(); settle();
      chk($sformatf("t_err_low%0d", i), 32'(bus_err_o), 32'd0);
    end
    tick(); settle();
    chk("t_err_set", 32'(bus_err_o), 32'd1);
    chk("t_still_req", 32'(ram_req_o), 32'd1);
    chk("t_stall_mem", 32'(stallreq_mem_o), 32'd1);
    tick(); ram_ack_i = 1'b1; ram_data_i = 32'hA5A5A5A5; settle();
    chk("t_late_memv", 32'(mem_valid_o), 32'd1);
    tick(); ram_ack_i = 1'b0; mem_req_i = 1'b0; settle();
    chk("t_err_sticky", 32'(bus_err_o), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0; settle();
    chk("t_err_clr", 32'(bus_err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
